// File: rtl/zeroheti_mtimer.sv
// RISC-V machine timer: 64-bit mtime with prescaler, mtimecmp compare and
// level interrupt, exposed as five 32-bit registers on an OBI-style bus.
module zeroheti_mtimer #(
  parameter logic [31:0] BaseAddr = 32'h0000_2100,
  parameter int unsigned NumRegs  = 5,
  parameter int unsigned PrescW   = 8
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        irq_o
);

  localparam int unsigned WinBytes = 4 * NumRegs;
  localparam logic [31:0] CtrlMask = {{(24 - PrescW){1'b0}}, {PrescW{1'b1}}, 8'h01};

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

  logic [63:0]       mtime_q, mtime_d;
  logic [63:0]       mtimecmp_q, mtimecmp_d;
  logic [31:0]       ctrl_q, ctrl_d;
  logic [PrescW-1:0] presc_cnt_q, presc_cnt_d;
  logic              rvalid_q, err_q, irq_q;
  logic [31:0]       rdata_q, rd_val;

  logic [31:0]       offset;
  logic              acc_err, wr_ok, tick, en;
  logic              wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl;
  logic [PrescW-1:0] presc;

  // Address decode: offsets below BaseAddr wrap to large values and fail the window check.
  assign offset  = addr_i - BaseAddr;
  assign acc_err = (addr_i[1:0] != 2'b00) || (addr_i < BaseAddr) || (offset >= 32'(WinBytes));
  assign wr_ok   = req_i && we_i && !acc_err;

  assign wr_mtime_lo = wr_ok && (offset == 32'h00);
  assign wr_mtime_hi = wr_ok && (offset == 32'h04);
  assign wr_cmp_lo   = wr_ok && (offset == 32'h08);
  assign wr_cmp_hi   = wr_ok && (offset == 32'h0C);
  assign wr_ctrl     = wr_ok && (offset == 32'h10);

  assign en    = ctrl_q[0];
  assign presc = ctrl_q[8 +: PrescW];
  assign tick  = en && (presc_cnt_q == presc);

  // Next-state: counting first, then bus writes override (mtime write drops the increment).
  always_comb begin
    mtime_d     = mtime_q;
    mtimecmp_d  = mtimecmp_q;
    ctrl_d      = ctrl_q;
    presc_cnt_d = presc_cnt_q;
    if (tick) begin
      mtime_d     = mtime_q + 64'd1;
      presc_cnt_d = '0;
    end else if (en) begin
      presc_cnt_d = presc_cnt_q + PrescW'(1);
    end
    if (wr_mtime_lo || wr_mtime_hi) mtime_d = mtime_q;
    if (wr_mtime_lo) mtime_d[31:0]    = merge_bytes(mtime_q[31:0], wdata_i, be_i);
    if (wr_mtime_hi) mtime_d[63:32]   = merge_bytes(mtime_q[63:32], wdata_i, be_i);
    if (wr_cmp_lo)   mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wdata_i, be_i);
    if (wr_cmp_hi)   mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata_i, be_i);
    if (wr_ctrl) begin
      ctrl_d      = merge_bytes(ctrl_q, wdata_i, be_i) & CtrlMask;
      presc_cnt_d = '0;
    end
  end

  always_comb begin
    rd_val = '0;
    unique case (offset)
      32'h00:  rd_val = mtime_q[31:0];
      32'h04:  rd_val = mtime_q[63:32];
      32'h08:  rd_val = mtimecmp_q[31:0];
      32'h0C:  rd_val = mtimecmp_q[63:32];
      32'h10:  rd_val = ctrl_q;
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      ctrl_q      <= '0;
      presc_cnt_q <= '0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      ctrl_q      <= ctrl_d;
      presc_cnt_q <= presc_cnt_d;
    end
  end

  // One response per request, one cycle later; rdata holds between responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= req_i;
      if (req_i) begin
        err_q   <= acc_err;
        rdata_q <= (we_i || acc_err) ? 32'h0 : rd_val;
      end
      irq_q <= (mtime_q >= mtimecmp_q);
    end
  end

  assign gnt_o    = req_i;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_zeroheti_mtimer.sv
// Directed bench for zeroheti_mtimer: register access, counting, carry/wrap,
// interrupt timing, error responses, byte writes and mid-request reset.
module tb_zeroheti_mtimer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_i, we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i, wdata_i;
  logic        gnt_o, rvalid_o, err_o, irq_o;
  logic [31:0] rdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic        g, v, e;
  logic [31:0] d;

  always #5 clk_i = ~clk_i;

  zeroheti_mtimer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i),
    .be_i(be_i), .addr_i(addr_i), .wdata_i(wdata_i), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .irq_o(irq_o)
  );

  // Issue one request at a negedge, return the response sampled at the following negedge.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic gnt, output logic rv,
                     output logic [31:0] rd, output logic er);
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; be_i = be;
    #1 gnt = gnt_o;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 1'b0; we_i = 1'b0;
    rv = rvalid_o; rd = rdata_o; er = err_o;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    bus(1'b1, addr, wdata, 4'hF, g, v, d, e);
  endtask

  task automatic test_reset();
    repeat (10) @(negedge clk_i);
    n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %b exp 0", irq_o); end
    n_tests++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid got %b exp 0", rvalid_o); end
    bus(1'b0, 32'h2100, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (g !== 1'b1) begin n_fail++; $display("FAIL reset_gnt got %b exp 1", g); end
    n_tests++; if (v !== 1'b1) begin n_fail++; $display("FAIL reset_rd_rvalid got %b exp 1", v); end
    n_tests++; if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL reset_rd_mtime got %h/%b exp 0/0", d, e); end
    @(negedge clk_i);
    n_tests++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rvalid_pulse got %b exp 0", rvalid_o); end
  endtask

  task automatic test_count();
    wr(32'h2110, 32'h0000_0301);
    repeat (16) @(negedge clk_i);
    bus(1'b0, 32'h2100, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'd4) begin n_fail++; $display("FAIL count_presc3 got %h exp 4", d); end
    bus(1'b0, 32'h2110, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'h0000_0301) begin n_fail++; $display("FAIL ctrl_read got %h exp 301", d); end
    wr(32'h2110, 32'h0);
    bus(1'b0, 32'h2100, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'd4) begin n_fail++; $display("FAIL count_hold got %h exp 4", d); end
  endtask

  task automatic test_carry();
    wr(32'h2104, 32'h0);
    wr(32'h2100, 32'hFFFF_FFFE);
    wr(32'h2110, 32'h1);
    repeat (2) @(negedge clk_i);
    bus(1'b0, 32'h2104, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL carry_hi got %h exp 1", d); end
    bus(1'b0, 32'h2100, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL carry_lo got %h exp 1", d); end
    wr(32'h2110, 32'h0);
  endtask

  task automatic test_wrap();
    wr(32'h2104, 32'hFFFF_FFFF);
    wr(32'h2100, 32'hFFFF_FFFF);
    wr(32'h2110, 32'h1);
    n_tests++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_equal got %b exp 1", irq_o); end
    @(negedge clk_i);
    bus(1'b0, 32'h2104, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'h0 || e !== 1'b0) begin n_fail++; $display("FAIL wrap_hi got %h/%b exp 0/0", d, e); end
    bus(1'b0, 32'h2100, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL wrap_lo got %h exp 1", d); end
    n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL wrap_irq got %b exp 0", irq_o); end
  endtask

  task automatic test_irq();
    wr(32'h2110, 32'h0);
    wr(32'h2108, 32'h10);
    wr(32'h210C, 32'h0);
    wr(32'h2100, 32'h0);
    wr(32'h2104, 32'h0);
    wr(32'h2110, 32'h1);
    repeat (16) @(negedge clk_i);
    n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b exp 0", irq_o); end
    @(negedge clk_i);
    n_tests++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_rise got %b exp 1", irq_o); end
    wr(32'h2108, 32'h100);
    n_tests++; if (irq_o !== 1'b1) begin n_fail++; $display("FAIL irq_hold got %b exp 1", irq_o); end
    @(negedge clk_i);
    n_tests++; if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_fall got %b exp 0", irq_o); end
  endtask

  task automatic test_errors();
    logic [31:0] bad [3] = '{32'h2114, 32'h2102, 32'h20FC};
    logic [31:0] exp [5] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'hCAFE_0000, 32'h0000_0001, 32'h0000_FE00};
    wr(32'h2110, 32'h0);
    wr(32'h2100, 32'h1234_5678);
    wr(32'h2104, 32'h9ABC_DEF0);
    wr(32'h2108, 32'hCAFE_0000);
    wr(32'h210C, 32'h0000_0001);
    wr(32'h2110, 32'hFFFF_FE00);
    for (int i = 0; i < 3; i++) begin
      bus(1'b0, bad[i], 32'h0, 4'hF, g, v, d, e);
      n_tests++; if (v !== 1'b1 || e !== 1'b1 || d !== 32'h0) begin
        n_fail++; $display("FAIL err_rd_%h got v%b e%b %h exp v1 e1 0", bad[i], v, e, d);
      end
      bus(1'b1, bad[i] | 32'h1, 32'hFFFF_FFFF, 4'hF, g, v, d, e);
      n_tests++; if (v !== 1'b1 || e !== 1'b1) begin
        n_fail++; $display("FAIL err_wr_%h got v%b e%b exp v1 e1", bad[i], v, e);
      end
    end
    bus(1'b1, 32'h2114, 32'hFFFF_FFFF, 4'hF, g, v, d, e);
    bus(1'b1, 32'h2100, 32'hFFFF_FFFF, 4'h0, g, v, d, e);
    n_tests++; if (v !== 1'b1 || e !== 1'b0) begin n_fail++; $display("FAIL be0_resp got v%b e%b exp v1 e0", v, e); end
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, 32'h2100 + 32'(4 * i), 32'h0, 4'hF, g, v, d, e);
      n_tests++; if (d !== exp[i] || e !== 1'b0) begin
        n_fail++; $display("FAIL regs_intact_%0d got %h exp %h", i, d, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    wr(32'h2108, 32'h5555_AAAA);
    bus(1'b0, 32'h2108, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'h5555_AAAA) begin n_fail++; $display("FAIL b2b_cmp got %h exp 5555aaaa", d); end
    bus(1'b1, 32'h210C, 32'h0000_7700, 4'h2, g, v, d, e);
    bus(1'b0, 32'h210C, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'h0000_7701) begin n_fail++; $display("FAIL b2b_byte got %h exp 7701", d); end
  endtask

  task automatic test_byte_write();
    wr(32'h2100, 32'h1122_3344);
    wr(32'h2104, 32'h0);
    wr(32'h2110, 32'h0000_0301);
    repeat (2) @(negedge clk_i);
    bus(1'b1, 32'h2100, 32'h0000_AB00, 4'b0010, g, v, d, e);
    bus(1'b0, 32'h2100, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'h1122_AB44) begin n_fail++; $display("FAIL byte_wr got %h exp 1122ab44", d); end
    repeat (3) @(negedge clk_i);
    bus(1'b0, 32'h2100, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'h1122_AB45) begin n_fail++; $display("FAIL byte_resume got %h exp 1122ab45", d); end
    bus(1'b0, 32'h2104, 32'h0, 4'hF, g, v, d, e);
    n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL byte_hi got %h exp 0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp [5] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h2104; wdata_i = 32'hDEAD_BEEF; be_i = 4'hF;
    #2 rst_ni = 1'b0;
    #1;
    n_tests++; if (rvalid_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_rvalid got %b exp 0", rvalid_o); end
    @(posedge clk_i);
    @(negedge clk_i);
    n_tests++; if (rvalid_o !== 1'b0 || irq_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_hold got v%b irq%b exp 0/0", rvalid_o, irq_o);
    end
    req_i = 1'b0; we_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, 32'h2100 + 32'(4 * i), 32'h0, 4'hF, g, v, d, e);
      n_tests++; if (d !== exp[i]) begin n_fail++; $display("FAIL rst_reg_%0d got %h exp %h", i, d, exp[i]); end
    end
  endtask

  initial begin
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = 32'h0; wdata_i = 32'h0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    test_reset();
    test_count();
    test_carry();
    test_wrap();
    test_irq();
    test_errors();
    test_back_to_back();
    test_byte_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zeroheti_mtimer.md
Name: zeroheti_mtimer

Overview:
- Memory-mapped RISC-V machine timer. It is the responder at the mtimer window, 0x0000_2100–0x0000_2113: five 32-bit registers, with 0x2114 the first address outside the window.
- Sits behind the core-side address decoder on the OBI-style data bus, as the counterpart to the initiator that uses the address map.
- Keeps a 64-bit free-running mtime with a programmable prescaler, compares it against mtimecmp, and drives the machine timer interrupt to the core/HETIC.

Parameters:
- BaseAddr, 32'h0000_2100: base of the register window; word offset = addr_i - BaseAddr.
- NumRegs, 5: number of 32-bit registers (window length 4*NumRegs bytes).
- PrescW, 8: prescaler counter width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  bus request
- gnt_o  out  1  grant
- we_i  in  1  write enable
- be_i  in  4  byte enables
- addr_i  in  32  byte address
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  error response
- irq_o  out  1  machine timer interrupt

Behaviour:
- Reset:
  - Clock is clk_i; reset is rst_ni, asynchronous and active-low.
  - Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, ctrl=0, prescaler count=0.
  - Output reset values: gnt_o=0 (combinational), rvalid_o=0, rdata_o=0, err_o=0, irq_o=0.
- Register map (offsets from BaseAddr):
  - 0x00 mtime[31:0], 0x04 mtime[63:32].
  - 0x08 mtimecmp[31:0], 0x0C mtimecmp[63:32].
  - 0x10 ctrl: bit0 EN, bits[8+PrescW-1:8] PRESC, other bits read 0, writes ignored.
- Handshake:
  - gnt_o = req_i combinationally; every request is accepted in the same cycle, with no back-pressure.
  - Exactly one response per accepted request, one cycle later: rvalid_o=1 for one cycle, with rdata_o/err_o valid in that cycle.
  - Back-to-back requests are allowed every cycle.
  - rdata_o=0 for writes and errors; rdata_o holds its last value while rvalid_o=0 (not checked).
- Errors:
  - err_o=1 if addr_i[1:0]!=0, or offset >= 4*NumRegs, or addr_i < BaseAddr.
  - Erroring writes have no side effect; erroring reads return 0.
- Writes:
  - Byte-granular per be_i; be_i=0 is a legal no-op with an OK response.
  - The written value is visible to a read issued the next cycle.
- Counting:
  - When EN=1, the prescaler counts 0..PRESC. On the cycle it equals PRESC it wraps to 0 and mtime increments by 1, so PRESC=0 gives an increment every cycle.
  - When EN=0, the prescaler and mtime hold.
  - Writing ctrl clears the prescaler count.
- Simultaneous events:
  - A bus write to either mtime half takes priority over the increment in the same cycle: the written bytes win, and unwritten bytes keep their pre-increment values (increment dropped for that cycle).
  - mtime wraps from 2^64-1 to 0 without an error.
  - The 64-bit increment carries atomically across halves.
  - A read returns the value registered before the access cycle's update.
  - Software reads hi/lo/hi to get a consistent 64-bit value; no shadow latch.
- Interrupt:
  - irq_o is registered: irq_o(t+1) = (mtime(t) >= mtimecmp(t)), unsigned 64-bit compare, evaluated on post-update register values.
  - irq_o is level-sensitive. It deasserts the cycle after a mtimecmp write makes mtimecmp > mtime, or after an mtime write drops below mtimecmp.
  - irq_o does not depend on EN.
- Reset mid-transaction: a pending response is dropped (rvalid_o forced 0); no partial writes persist.

Test Plan:
- Reset then idle 10 cycles -> irq_o=0, rvalid_o=0; read 0x2100 -> rdata 0, err 0, one cycle after req.
- Write ctrl=0x0000_0301 (EN=1, PRESC=3); wait 16 cycles; read 0x2100 -> 4 (±1 per documented phase); read 0x2110 -> 0x0000_0301.
- Write mtime hi=0, lo=0xFFFF_FFFE, EN=1, PRESC=0; after 3 cycles read hi -> 1 (carry crosses halves).
- mtimecmp=0x0000_0000_0000_0010, mtime=0, EN=1, PRESC=0 -> irq_o rises exactly one cycle after mtime reaches 0x10; write mtimecmp lo=0x100 -> irq_o falls next cycle.
- Accesses at 0x2114, 0x2102 and 0x20FC -> err_o=1 with rvalid_o; a write to 0x2114 leaves all registers unchanged.
- Write 0xAB to mtime lo with be_i=4'b0010 while counting, mid-prescale -> byte1=0xAB, other bytes unchanged, no increment that cycle; assert rst_ni low mid-request -> rvalid_o=0 immediately, all registers at reset values.
